// File: rtl/orion_types.sv
// Shared CSR-file types for the orion pipeline.
//   csr_addr_t  : 12-bit CSR address, with named counter addresses
//   csr_ops_t   : CSR read-modify-write operation
//   mem_csrf_t  : MEM -> CSR file request (addr, operand, op, ren, wen)
//   wb_csrf_t   : WB  -> CSR file retire strobe
//   csrf_wb_t   : CSR file -> WB read data
package orion_types;

  localparam int XLEN      = 32;
  localparam int CSR_CNT_W = 64;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_CYCLE     = 12'hC00;
  localparam csr_addr_t CSR_INSTRET   = 12'hC02;
  localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
  localparam csr_addr_t CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_ops_t;

  typedef struct packed {
    csr_addr_t        addr;
    logic [XLEN-1:0]  operand;
    csr_ops_t         op;
    logic             ren;
    logic             wen;
  } mem_csrf_t;

  typedef struct packed {
    logic instr_retired;
  } wb_csrf_t;

  typedef struct packed {
    logic [XLEN-1:0] rd_v;
  } csrf_wb_t;

  // Write value for a read-modify-write CSR op; NONE leaves the old value.
  function automatic logic [XLEN-1:0] csr_alu(input csr_ops_t        op,
                                              input logic [XLEN-1:0] old_v,
                                              input logic [XLEN-1:0] opnd);
    logic [XLEN-1:0] r;
    r = old_v;
    case (op)
      CSR_OP_RW: r = opnd;
      CSR_OP_RS: r = old_v | opnd;
      CSR_OP_RC: r = old_v & ~opnd;
      default:   r = old_v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/orion_csr_counter64.sv
// Free-running counter with split XLEN-half writes.
//   clk, rst_n : clock, async active-low reset (clears count)
//   inc_i      : increment enable
//   wr_lo_i    : write wdata_i into the low XLEN bits
//   wr_hi_i    : write wdata_i into the high CNT_W-XLEN bits
//   cnt_o      : current count
// A write to either half wins over the increment for that cycle, so software
// sees exactly the value it wrote with no carry rippling into the other half.
// CNT_W must lie in (XLEN, 2*XLEN].
module orion_csr_counter64
  import orion_types::*;
#(
  parameter int CNT_W = CSR_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int HI_W = CNT_W - XLEN;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)      cnt_d[XLEN-1:0]     = wdata_i;
    else if (wr_hi_i) cnt_d[CNT_W-1:XLEN] = wdata_i[HI_W-1:0];
    // Full-width add: low-half overflow carries into the high half in the
    // same cycle, and all-ones wraps to zero.
    else if (inc_i)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/orion_csr_file.sv
// Performance-counter CSR file (mcycle / minstret plus user shadows).
//   clk, rst_n   : clock, async active-low reset
//   mem_csrf_i   : CSR request from MEM (addr, operand, op, ren, wen)
//   wb_csrf_i    : instr_retired strobe from WB
//   csrf_wb_o    : registered read data (valid one cycle after ren, held
//                  while ren=0)
//   illegal_o    : registered flag for the previous cycle's request hitting
//                  an unimplemented address, a read-only shadow write, or a
//                  write with op=NONE
// Reads see pre-update state, so a read+write in one cycle returns the old
// value.
module orion_csr_file
  import orion_types::*;
#(
  parameter int CNT_W = CSR_CNT_W
) (
  input  logic      clk,
  input  logic      rst_n,
  input  mem_csrf_t mem_csrf_i,
  input  wb_csrf_t  wb_csrf_i,
  output csrf_wb_t  csrf_wb_o,
  output logic      illegal_o
);

  logic [CNT_W-1:0]  mcycle, minstret;
  logic [2*XLEN-1:0] mcycle_x, minstret_x;

  // Zero-extend so the high half reads cleanly for any CNT_W <= 2*XLEN.
  assign mcycle_x   = (2*XLEN)'(mcycle);
  assign minstret_x = (2*XLEN)'(minstret);

  logic [XLEN-1:0] rd_val, wr_val;
  logic            hit, ro, wr_ok, ill_d;
  logic            wr_cyc_lo, wr_cyc_hi, wr_ret_lo, wr_ret_hi;
  logic [XLEN-1:0] rd_q;
  logic            ill_q;

  // Address decode and read mux.
  always_comb begin
    rd_val = '0;
    hit    = 1'b1;
    ro     = 1'b0;
    case (mem_csrf_i.addr)
      CSR_MCYCLE:    rd_val = mcycle_x[XLEN-1:0];
      CSR_MCYCLEH:   rd_val = mcycle_x[2*XLEN-1:XLEN];
      CSR_MINSTRET:  rd_val = minstret_x[XLEN-1:0];
      CSR_MINSTRETH: rd_val = minstret_x[2*XLEN-1:XLEN];
      CSR_CYCLE:     begin rd_val = mcycle_x[XLEN-1:0];          ro = 1'b1; end
      CSR_CYCLEH:    begin rd_val = mcycle_x[2*XLEN-1:XLEN];     ro = 1'b1; end
      CSR_INSTRET:   begin rd_val = minstret_x[XLEN-1:0];        ro = 1'b1; end
      CSR_INSTRETH:  begin rd_val = minstret_x[2*XLEN-1:XLEN];   ro = 1'b1; end
      default:       hit = 1'b0;
    endcase
  end

  // Write-value ALU works on the same pre-update value the read mux sees.
  assign wr_val = csr_alu(mem_csrf_i.op, rd_val, mem_csrf_i.operand);

  assign wr_ok = mem_csrf_i.wen && hit && !ro && (mem_csrf_i.op != CSR_OP_NONE);

  assign wr_cyc_lo = wr_ok && (mem_csrf_i.addr == CSR_MCYCLE);
  assign wr_cyc_hi = wr_ok && (mem_csrf_i.addr == CSR_MCYCLEH);
  assign wr_ret_lo = wr_ok && (mem_csrf_i.addr == CSR_MINSTRET);
  assign wr_ret_hi = wr_ok && (mem_csrf_i.addr == CSR_MINSTRETH);

  assign ill_d = ((mem_csrf_i.ren || mem_csrf_i.wen) && !hit) ||
                 (mem_csrf_i.wen && hit && (ro || mem_csrf_i.op == CSR_OP_NONE));

  orion_csr_counter64 #(.CNT_W(CNT_W)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (wr_cyc_lo),
    .wr_hi_i (wr_cyc_hi),
    .wdata_i (wr_val),
    .cnt_o   (mcycle)
  );

  orion_csr_counter64 #(.CNT_W(CNT_W)) u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (wb_csrf_i.instr_retired),
    .wr_lo_i (wr_ret_lo),
    .wr_hi_i (wr_ret_hi),
    .wdata_i (wr_val),
    .cnt_o   (minstret)
  );

  // Single output stage: read data only moves on ren, flag every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      if (mem_csrf_i.ren) rd_q <= rd_val;
      ill_q <= ill_d;
    end
  end

  assign csrf_wb_o.rd_v = rd_q;
  assign illegal_o      = ill_q;

endmodule

// File: doc/orion_csr_file.md
ORION_CSR_FILE -- requirements
Module: orion_csr_file

Interface
REQ-001 SHALL have parameter CNT_W, default 64, width of each performance counter (split into two XLEN halves).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_csrf_i  input  mem_csrf_t  CSR request from MEM stage: addr, operand, op, ren, wen.
REQ-005 SHALL have port wb_csrf_i  input  wb_csrf_t  instr_retired strobe from WB stage.
REQ-006 SHALL have port csrf_wb_o  output  csrf_wb_t  rd_v, read data to WB stage.
REQ-007 SHALL have port illegal_o  output  1  registered flag: last request hit an unimplemented or read-only-write address.

Function
REQ-008 SHALL implement mcycle (CSR_MCYCLE/CSR_MCYCLEH) and minstret (CSR_MINSTRET/CSR_MINSTRETH) as CNT_W-bit counters.
REQ-009 SHALL map CSR_CYCLE/CYCLEH and CSR_INSTRET/INSTRETH as read-only shadows of mcycle/minstret.
REQ-010 SHALL increment mcycle by 1 every cycle out of reset, wrapping 2^64-1 -> 0.
REQ-011 SHALL increment minstret by 1 in each cycle wb_csrf_i.instr_retired=1, wrapping 2^64-1 -> 0.
REQ-012 SHALL sample read data when ren=1 and present it on csrf_wb_o.rd_v exactly one cycle later (registered, latency 1).
REQ-013 SHALL return the pre-update value of the addressed CSR for a same-cycle read+write (read-before-write).
REQ-014 SHALL hold csrf_wb_o.rd_v unchanged in cycles after ren=0.
REQ-015 SHALL return 0 for reads of unimplemented addresses.
REQ-016 SHALL compute write value when wen=1: CSR_OP_RW -> operand; CSR_OP_RS -> old|operand; CSR_OP_RC -> old&~operand.
REQ-017 SHALL treat op=2'b00 with wen=1 as no write and set illegal_o.
REQ-018 SHALL write only the addressed XLEN half; the other half holds its value.
REQ-019 SHALL, in a cycle where either half of a counter is written, suppress that counter's increment (write wins, no carry into other half).
REQ-020 SHALL ignore writes to read-only shadows and unimplemented addresses and set illegal_o the next cycle.
REQ-021 SHALL set illegal_o the cycle after a request (ren|wen) to an unimplemented address; cleared the cycle after any legal request or idle cycle.
REQ-022 SHALL carry low-half overflow into high half atomically in the same increment (0x0000_0000_FFFF_FFFF -> 0x0000_0001_0000_0000).
REQ-023 SHALL honour wen/ren only; no internal decode of funct3 or rs1=0.

Reset
REQ-024 SHALL clear mcycle, minstret, csrf_wb_o.rd_v and illegal_o to 0 asynchronously on rst_n=0.
REQ-025 SHALL discard an in-flight read on reset; first cycle after deassert mcycle becomes 1.
REQ-026 SHALL ignore requests and retire strobes while rst_n=0.

Structure
REQ-027 SHALL take csr_addr_t, csr_ops_t, mem_csrf_t, csrf_wb_t, wb_csrf_t from orion_types; SHALL add CSR_CNT_W=64 constant there.
REQ-028 SHALL contain sub-module orion_csr_counter64 (inc enable, half-select write, 64-bit state), instantiated for mcycle and minstret.
REQ-029 SHALL keep read mux and write-value ALU in orion_csr_file, combinational, single registered output stage.

Verification
REQ-030 Reset release, idle 10 cycles, read CSR_MCYCLE -> rd_v=10 one cycle after ren (value at read cycle).
REQ-031 Write RW CSR_MCYCLE operand 0xFFFF_FFFF, next cycle read CSR_MCYCLEH twice over 2 cycles -> 0 then 1 (carry).
REQ-032 Assert instr_retired 5 of 8 cycles, read CSR_INSTRET -> 5; read CSR_MINSTRETH -> 0.
REQ-033 minstret=0x0F0; RS operand 0x00F on MINSTRET with instr_retired=1 same cycle -> next read 0x0FF (no increment).
REQ-034 RC operand 0x1 on CSR_CYCLE -> mcycle unaffected, illegal_o=1 next cycle, 0 the cycle after.
REQ-035 Read addr 0x7B0 -> rd_v=0, illegal_o=1; assert rst_n=0 mid-run -> all outputs 0 immediately.
